sprite_rom_arbiter: RTL and testbench

Round-robin arbiter that shares one combinational sprite bitmap ROM (8-bit address, 8-bit data) among several sprite renderers, such as multiple tank controllers fetching rows during horizontal blanking. Each requester presents an address with a level request. The arbiter issues one ROM access per clock and returns the byte with a one-cycle acknowledge. It sits between the per-tank renderers and the single shared bitmap ROM, so only one ROM instance is needed.

---
 rtl/sprite_rom_arbiter.sv | 94 +++++++++
 tb/tb_sprite_rom_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one combinational sprite bitmap ROM among NUM_REQ renderers.
// Two-stage pipeline: issue (grant + ROM address) then return (ack + registered ROM byte).
module sprite_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rd_data,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_bits
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_ack;
  logic [NUM_REQ-1:0] r_pending;
  logic [DATA_W-1:0]  r_rd_data;
  logic [ADDR_W-1:0]  r_rom_addr;
  logic [PTR_W-1:0]   r_ptr;

  logic [NUM_REQ-1:0] w_elig;
  logic               w_lo_found;
  logic               w_hi_found;
  logic [PTR_W-1:0]   w_lo_win;
  logic [PTR_W-1:0]   w_hi_win;
  logic               w_found;
  logic [PTR_W-1:0]   w_win;
  logic [PTR_W-1:0]   w_ptr_next;
  logic [NUM_REQ-1:0] w_gnt_next;
  logic [ADDR_W-1:0]  w_addr;

  assign w_elig = req & ~r_pending;

  // Rotating priority: lowest eligible index at or above ptr wins, else wrap to lowest overall.
  always_comb begin
    w_lo_found = 1'b0;
    w_hi_found = 1'b0;
    w_lo_win   = '0;
    w_hi_win   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_lo_found = 1'b1;
        w_lo_win   = PTR_W'(i);
      end
      if (w_elig[i] && (PTR_W'(i) >= r_ptr)) begin
        w_hi_found = 1'b1;
        w_hi_win   = PTR_W'(i);
      end
    end
  end

  assign w_found    = w_lo_found;
  assign w_win      = w_hi_found ? w_hi_win : w_lo_win;
  assign w_ptr_next = (w_win == LAST_IDX) ? '0 : w_win + 1'b1;
  assign w_gnt_next = w_found ? (NUM_REQ'(1) << w_win) : '0;
  assign w_addr     = req_addr[w_win*ADDR_W +: ADDR_W];

  // A requester is pending from its grant edge until its ack edge; the two never collide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gnt      <= '0;
      r_ack      <= '0;
      r_pending  <= '0;
      r_rd_data  <= '0;
      r_rom_addr <= '0;
      r_ptr      <= '0;
    end else begin
      r_gnt     <= w_gnt_next;
      r_ack     <= r_gnt;
      r_pending <= (r_pending & ~r_gnt) | w_gnt_next;
      if (|r_gnt) begin
        r_rd_data <= rom_bits;
      end
      if (w_found) begin
        r_rom_addr <= w_addr;
        r_ptr      <= w_ptr_next;
      end
    end
  end

  assign gnt      = r_gnt;
  assign ack      = r_ack;
  assign rd_data  = r_rd_data;
  assign rom_addr = r_rom_addr;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboard bench for sprite_rom_arbiter: a cycle-level reference model queues expected
// outputs on each rising edge and an independent monitor compares them on the falling edge.
module tb_sprite_rom_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;

  logic                      clk;
  logic                      reset;
  logic [NUM_REQ-1:0]        reqVec;
  logic [NUM_REQ*ADDR_W-1:0] reqAddr;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        ack;
  logic [DATA_W-1:0]         rdData;
  logic [ADDR_W-1:0]         romAddr;
  logic [DATA_W-1:0]         romBits;

  logic [ADDR_W-1:0] addr [NUM_REQ];

  int testsRun  = 0;
  int failCount = 0;

  typedef struct {
    logic [NUM_REQ-1:0] gnt;
    logic [ADDR_W-1:0]  romAddr;
    logic [NUM_REQ-1:0] ack;
    logic [DATA_W-1:0]  data;
  } expT;

  expT expQ[$];

  sprite_rom_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (reqVec),
    .req_addr(reqAddr),
    .gnt     (gnt),
    .ack     (ack),
    .rd_data (rdData),
    .rom_addr(romAddr),
    .rom_bits(romBits)
  );

  // Shared bitmap ROM stand-in; address 8'h24 holds the byte the single-requester case expects.
  function automatic logic [DATA_W-1:0] romFn(input logic [ADDR_W-1:0] a);
    if (a == 8'h24) return 8'hA5;
    return (a * 8'd37 + 8'd11) ^ 8'h3C;
  endfunction

  assign romBits = romFn(romAddr);
  assign reqAddr = {addr[3], addr[2], addr[1], addr[0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input int cycles);
    reqVec = r;
    repeat (cycles) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Reference model: requesters with an outstanding access are skipped; search begins at ptr.
  int mPtr;
  int mLastGnt;
  int mWin;
  int mIdx;
  bit mPend [NUM_REQ];
  logic [ADDR_W-1:0] mRomAddr;

  initial begin
    expT e;
    forever begin
      @(posedge clk);
      if (!reset) begin
        mPtr     = 0;
        mLastGnt = -1;
        mRomAddr = '0;
        for (int i = 0; i < NUM_REQ; i++) mPend[i] = 1'b0;
      end else begin
        mWin = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
          mIdx = (mPtr + k) % NUM_REQ;
          if (mWin < 0 && reqVec[mIdx] && !mPend[mIdx]) mWin = mIdx;
        end
        e.ack  = (mLastGnt >= 0) ? NUM_REQ'(1 << mLastGnt) : '0;
        e.data = romFn(mRomAddr);
        if (mLastGnt >= 0) mPend[mLastGnt] = 1'b0;
        if (mWin >= 0) begin
          mPend[mWin] = 1'b1;
          mPtr        = (mWin + 1) % NUM_REQ;
          mRomAddr    = addr[mWin];
          e.gnt       = NUM_REQ'(1 << mWin);
        end else begin
          e.gnt = '0;
        end
        mLastGnt  = mWin;
        e.romAddr = mRomAddr;
        expQ.push_back(e);
      end
    end
  end

  // Monitor: consumes one expected record per active cycle.
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        expQ.delete();
      end else if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("gnt", 32'(gnt), 32'(e.gnt));
        checkOutput("rom_addr", 32'(romAddr), 32'(e.romAddr));
        checkOutput("ack", 32'(ack), 32'(e.ack));
        if (e.ack != '0) checkOutput("rd_data", 32'(rdData), 32'(e.data));
      end
    end
  end

  // Random driver honouring the protocol: hold req/address until ack, optional drop after grant.
  task automatic randomTraffic(input int cycles);
    repeat (cycles) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!reqVec[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            reqVec[i] = 1'b1;
            addr[i]   = ADDR_W'($urandom);
          end
        end else if (ack[i]) begin
          if ($urandom_range(0, 2) == 0) reqVec[i] = 1'b0;
          else addr[i] = ADDR_W'($urandom);
        end else if (gnt[i] && $urandom_range(0, 3) == 0) begin
          reqVec[i] = 1'b0;
        end
      end
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    bit seen;
    reset  = 1'b0;
    reqVec = '0;
    for (int i = 0; i < NUM_REQ; i++) addr[i] = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_gnt", 32'(gnt), 32'h0);
    checkOutput("reset_ack", 32'(ack), 32'h0);
    checkOutput("reset_rd_data", 32'(rdData), 32'h0);
    checkOutput("reset_rom_addr", 32'(romAddr), 32'h0);
    reset = 1'b1;

    addr[0] = 8'h24;
    applyStimulus(4'b0001, 7);
    applyStimulus(4'b0000, 3);

    addr[0] = 8'h11; addr[1] = 8'h22; addr[2] = 8'h33; addr[3] = 8'h44;
    applyStimulus(4'b1111, 12);
    applyStimulus(4'b0000, 3);

    applyStimulus(4'b1000, 1);
    applyStimulus(4'b1001, 5);
    applyStimulus(4'b0000, 3);

    addr[2] = 8'h5C;
    applyStimulus(4'b0100, 1);
    applyStimulus(4'b0000, 6);

    addr[2] = 8'h77;
    applyStimulus(4'b0100, 1);
    reqVec = '0;
    seen   = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      if (gnt == 4'b0100) seen = 1'b1;
      else begin
        @(posedge clk);
        #2;
      end
    end
    checkOutput("gnt_before_reset", 32'(gnt), 32'h4);
    reset = 1'b0;
    #1;
    checkOutput("async_gnt", 32'(gnt), 32'h0);
    checkOutput("async_ack", 32'(ack), 32'h0);
    checkOutput("async_rd_data", 32'(rdData), 32'h0);
    checkOutput("async_rom_addr", 32'(romAddr), 32'h0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    applyStimulus(4'b1111, 8);
    applyStimulus(4'b0000, 10);

    reqVec = '0;
    randomTraffic(400);
    applyStimulus(4'b0000, 4);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
